// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, column patterns
// and small helpers for the active-low one-hot column and row vectors.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_IDLE  = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    // Active-low one-hot column drive to its index; anything else maps to 0.
    function automatic logic [1:0] col_to_index(input logic [3:0] col_drive);
        logic [1:0] idx;
        case (col_drive)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest-numbered row pulled low wins when several keys share a column.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] next_col(input logic [3:0] col_drive);
        return {col_drive[2:0], col_drive[3]};
    endfunction

endpackage

// File: rtl/keypad_debounce_scanner_scan_tick_gen.sv
// Free-running divider producing a one-clock tick every SCAN_DIV clocks,
// on the cycle where the divider sits at its terminal count.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_ONE;
        end
    end

    assign tick = (r_div == DIV_LAST);

endmodule

// File: rtl/keypad_debounce_scanner.sv
// 4x4 active-low keypad scanner with press/release debouncing in scan ticks.
// Reports a stable key index, a held level and a one-clock new-press pulse.
module keypad_debounce_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] col,
    output logic [3:0] posicion,
    output logic       opr,
    output logic       key_valid,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit ONE_SHOT = (DEBOUNCE_CNT == 1);

    logic [3:0]       r_fs_meta;
    logic [3:0]       r_fs;
    state_t           r_state;
    logic [3:0]       r_col;
    logic [1:0]       r_cand_row;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_posicion;
    logic             r_opr;
    logic             r_key_valid;

    logic             w_tick;
    logic             w_any_low;
    logic             w_cand_high;
    logic [CNT_W-1:0] w_cnt_inc;
    state_t           w_state_nxt;
    logic [3:0]       w_col_nxt;
    logic [1:0]       w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_confirm;
    logic             w_release_done;
    logic [3:0]       w_posicion_nxt;
    logic             w_opr_nxt;
    logic             w_key_valid_nxt;

    scan_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Rows are asynchronous to clk; everything downstream sees only r_fs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fs_meta <= 4'b1111;
            r_fs      <= 4'b1111;
        end else begin
            r_fs_meta <= fila;
            r_fs      <= r_fs_meta;
        end
    end

    assign w_any_low   = (r_fs != COL_IDLE);
    assign w_cand_high = r_fs[r_cand_row];
    assign w_cnt_inc   = r_cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SCAN;
            r_col       <= COL_FIRST;
            r_cand_row  <= 2'd0;
            r_cnt       <= '0;
            r_posicion  <= 4'd0;
            r_opr       <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_cand_row  <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_posicion  <= w_posicion_nxt;
            r_opr       <= w_opr_nxt;
            r_key_valid <= w_key_valid_nxt;
        end
    end

    // The column only moves in SCAN or when a press/release attempt ends,
    // so a held key keeps its column driven and other keys stay invisible.
    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_cand_nxt     = r_cand_row;
        w_cnt_nxt      = r_cnt;
        w_confirm      = 1'b0;
        w_release_done = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (!w_any_low) begin
                        w_col_nxt = next_col(r_col);
                    end else begin
                        w_cand_nxt = lowest_low_row(r_fs);
                        if (ONE_SHOT) begin
                            w_confirm   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = HELD;
                        end else begin
                            w_cnt_nxt   = CNT_ONE;
                            w_state_nxt = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!w_cand_high) begin
                        if (w_cnt_inc == CNT_TGT) begin
                            w_confirm   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = HELD;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_col_nxt   = next_col(r_col);
                        w_state_nxt = SCAN;
                    end
                end
                HELD: begin
                    if (w_cand_high) begin
                        if (ONE_SHOT) begin
                            w_release_done = 1'b1;
                            w_cnt_nxt      = '0;
                            w_col_nxt      = next_col(r_col);
                            w_state_nxt    = SCAN;
                        end else begin
                            w_cnt_nxt   = CNT_ONE;
                            w_state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (w_cand_high) begin
                        if (w_cnt_inc == CNT_TGT) begin
                            w_release_done = 1'b1;
                            w_cnt_nxt      = '0;
                            w_col_nxt      = next_col(r_col);
                            w_state_nxt    = SCAN;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = HELD;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    // row*4 + col_index is simply the concatenation of the two 2-bit fields.
    always_comb begin
        w_posicion_nxt  = r_posicion;
        w_opr_nxt       = r_opr;
        w_key_valid_nxt = 1'b0;
        if (w_confirm) begin
            w_posicion_nxt  = {w_cand_nxt, col_to_index(r_col)};
            w_opr_nxt       = 1'b1;
            w_key_valid_nxt = 1'b1;
        end else if (w_release_done) begin
            w_opr_nxt = 1'b0;
        end
    end

    assign col       = r_col;
    assign posicion  = r_posicion;
    assign opr       = r_opr;
    assign key_valid = r_key_valid;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_debounce_scanner.sv
// Bench for keypad_debounce_scanner: a virtual 4x4 keypad answers the column
// drive, and a tick-level reference model predicts every output each cycle.
`timescale 1ns/1ps
module tb_keypad_debounce_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    localparam int PH_IDLE    = 0;
    localparam int PH_QUALIFY = 1;
    localparam int PH_HELD    = 2;
    localparam int PH_LETGO   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] fila;
    logic [3:0] col;
    logic [3:0] posicion;
    logic       opr;
    logic       key_valid;
    logic [1:0] dbg_state;

    logic [15:0] pressed = 16'h0000;
    bit          fila_force_low = 1'b1;

    int checks = 0;
    int errors = 0;
    int kv_seen = 0;

    // Reference model: integer column index, phase, candidate row, run length.
    int         m_ci;
    int         m_phase;
    int         m_row;
    int         m_run;
    logic [3:0] m_pos;
    logic       m_opr;
    logic       exp_kv;

    typedef struct {
        logic [15:0] mask;
        int          ticks;
        logic [3:0]  exp_col;
        logic        exp_opr;
        logic [3:0]  exp_pos;
        int          exp_kv;
    } seg_t;

    seg_t segs[13];

    keypad_debounce_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fila      (fila),
        .col       (col),
        .posicion  (posicion),
        .opr       (opr),
        .key_valid (key_valid),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] col_of(input int c);
        logic [3:0] v;
        v = 4'b1111;
        v[c] = 1'b0;
        return v;
    endfunction

    // Virtual keypad: a pressed key shorts its row to the driven column.
    always_comb begin
        fila = 4'b1111;
        if (fila_force_low) begin
            fila = 4'b0000;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (col == col_of(c) && pressed[r*4+c]) begin
                        fila[r] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ci    = 0;
        m_phase = PH_IDLE;
        m_row   = 0;
        m_run   = 0;
        m_pos   = 4'd0;
        m_opr   = 1'b0;
        exp_kv  = 1'b0;
    endtask

    task automatic model_tick(output bit confirm);
        int low_row;
        bit cand_low;
        confirm = 1'b0;
        low_row = -1;
        for (int r = 3; r >= 0; r--) begin
            if (pressed[r*4+m_ci]) low_row = r;
        end
        cand_low = pressed[m_row*4+m_ci];
        case (m_phase)
            PH_IDLE: begin
                if (low_row < 0) begin
                    m_ci = (m_ci + 1) % 4;
                end else begin
                    m_row   = low_row;
                    m_run   = 1;
                    m_phase = PH_QUALIFY;
                end
            end
            PH_QUALIFY: begin
                if (cand_low) begin
                    m_run++;
                end else begin
                    m_phase = PH_IDLE;
                    m_ci    = (m_ci + 1) % 4;
                end
            end
            PH_HELD: begin
                if (!cand_low) begin
                    m_run   = 1;
                    m_phase = PH_LETGO;
                end
            end
            default: begin
                if (cand_low) begin
                    m_phase = PH_HELD;
                end else begin
                    m_run++;
                end
            end
        endcase
        if (m_phase == PH_QUALIFY && m_run >= DEBOUNCE_CNT) begin
            m_phase = PH_HELD;
            m_pos   = 4'(m_row * 4 + m_ci);
            m_opr   = 1'b1;
            confirm = 1'b1;
        end
        if (m_phase == PH_LETGO && m_run >= DEBOUNCE_CNT) begin
            m_phase = PH_IDLE;
            m_opr   = 1'b0;
            m_ci    = (m_ci + 1) % 4;
        end
    endtask

    task automatic check_outputs();
        check("col", 32'(col), 32'(col_of(m_ci)));
        check("posicion", 32'(posicion), 32'(m_pos));
        check("opr", 32'(opr), 32'(m_opr));
        check("key_valid", 32'(key_valid), 32'(exp_kv));
        if (key_valid === 1'b1) kv_seen++;
    endtask

    // Holds a key mask for one tick period; keys change just after a tick.
    task automatic run_tick(input logic [15:0] mask);
        bit conf;
        pressed = mask;
        for (int e = 1; e <= SCAN_DIV; e++) begin
            @(posedge clk);
            exp_kv = 1'b0;
            if (e == SCAN_DIV) begin
                model_tick(conf);
                exp_kv = conf;
            end
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col"}, 32'(col), 32'h0000000e);
        check({tag, "_posicion"}, 32'(posicion), 32'h0);
        check({tag, "_opr"}, 32'(opr), 32'h0);
        check({tag, "_key_valid"}, 32'(key_valid), 32'h0);
    endtask

    task automatic async_reset(input string tag);
        #1;
        rst = 1'b0;
        #1;
        check_reset_values(tag);
        pressed = 16'h0000;
        @(negedge clk);
        check_reset_values(tag);
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mask;
        logic [15:0] prev_mask;
        segs[0]  = '{16'h0000,  2, 4'b1011, 1'b0, 4'd0, 0};
        segs[1]  = '{16'h0200,  8, 4'b1101, 1'b1, 4'd9, 1};
        segs[2]  = '{16'h0000,  2, 4'b1101, 1'b1, 4'd9, 1};
        segs[3]  = '{16'h0200,  5, 4'b1101, 1'b1, 4'd9, 1};
        segs[4]  = '{16'h0000,  4, 4'b0111, 1'b0, 4'd9, 1};
        segs[5]  = '{16'h0008,  1, 4'b0111, 1'b0, 4'd9, 1};
        segs[6]  = '{16'h0000,  1, 4'b1110, 1'b0, 4'd9, 1};
        segs[7]  = '{16'h0008,  8, 4'b0111, 1'b1, 4'd3, 2};
        segs[8]  = '{16'h0000,  5, 4'b1011, 1'b0, 4'd3, 2};
        segs[9]  = '{16'h4040,  8, 4'b1011, 1'b1, 4'd6, 3};
        segs[10] = '{16'h4041,  4, 4'b1011, 1'b1, 4'd6, 3};
        segs[11] = '{16'h0001, 10, 4'b1110, 1'b1, 4'd0, 4};
        segs[12] = '{16'h0000,  5, 4'b0111, 1'b0, 4'd0, 4};

        model_reset();
        rst = 1'b0;
        fila_force_low = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_values("reset_hold");
        end
        fila_force_low = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            for (int t = 0; t < segs[i].ticks; t++) begin
                run_tick(segs[i].mask);
            end
            check($sformatf("seg%0d_col", i), 32'(col), 32'(segs[i].exp_col));
            check($sformatf("seg%0d_opr", i), 32'(opr), 32'(segs[i].exp_opr));
            check($sformatf("seg%0d_posicion", i), 32'(posicion), 32'(segs[i].exp_pos));
            check($sformatf("seg%0d_kv_count", i), 32'(kv_seen), 32'(segs[i].exp_kv));
        end

        // Abort while qualifying a press on row0/col3.
        run_tick(16'h0008);
        async_reset("rst_mid_debounce");
        kv_seen = 0;
        run_tick(16'h0000);
        run_tick(16'h0000);
        check("after_rst_debounce_kv_count", 32'(kv_seen), 32'h0);

        // Abort while key 9 is confirmed and held.
        async_reset("rst_pre_held");
        for (int t = 0; t < 8; t++) run_tick(16'h0200);
        check("held_before_rst_opr", 32'(opr), 32'h1);
        check("held_before_rst_pos", 32'(posicion), 32'h9);
        async_reset("rst_mid_held");
        run_tick(16'h0000);
        check("after_rst_held_opr", 32'(opr), 32'h0);

        prev_mask = 16'h0000;
        for (int s = 0; s < 90; s++) begin
            case ($urandom_range(0, 3))
                0: mask = 16'h0000;
                1: begin
                    mask = 16'h0000;
                    mask[$urandom_range(0, 15)] = 1'b1;
                end
                2: begin
                    mask = 16'h0000;
                    mask[$urandom_range(0, 15)] = 1'b1;
                    mask[$urandom_range(0, 15)] = 1'b1;
                end
                default: mask = prev_mask;
            endcase
            prev_mask = mask;
            for (int t = 0; t < int'($urandom_range(1, 6)); t++) begin
                run_tick(mask);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_debounce_scanner.md
Name: keypad_debounce_scanner

Overview:
- Upstream stage of the register-bank/VGA/PWM path; replaces the raw keypad scanner.
- Scans a 4x4 active-low matrix keypad and debounces press and release in scan-tick units.
- Outputs a stable key index posicion (0-15) and a level opr that gates register-bank writes and the PWM output.
- Also outputs a one-cycle key_valid pulse per confirmed new press.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick (1 ms at 50 MHz); must be >= 2
DEBOUNCE_CNT, 10, consecutive agreeing ticks needed to confirm a press or a release; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
fila  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col  out  4  keypad column drive, active-low one-hot
posicion  out  4  confirmed key index = row*4 + col_index
opr  out  1  high while a confirmed key is held
key_valid  out  1  one-clk pulse when a new press is confirmed

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - col=4'b1110, posicion=0, opr=0, key_valid=0
  - fila synchroniser=4'b1111, state=SCAN, counters=0
- Reset asserted mid-operation aborts immediately to these values.
- fila passes through a 2-FF synchroniser (fs). All decisions use fs, sampled only on tick.
- Tick generator:
  - div counts 0..SCAN_DIV-1 and wraps; tick=1 for the single cycle when div==SCAN_DIV-1.
  - div width is clog2(SCAN_DIV). The debounce counter width is clog2(DEBOUNCE_CNT+1).
- Column order: 1110 -> 1101 -> 1011 -> 0111 -> 1110; col_index 0..3.
- The column advances only on a tick in SCAN, after sampling, so rows get one full tick period to settle.
- FSM, all transitions on tick only:
  - SCAN:
    - fs==1111: advance col.
    - Else: latch cand_row = lowest index with fs bit low, hold col, cnt=1.
      - If DEBOUNCE_CNT==1, confirm immediately (see below).
      - Otherwise go to DEBOUNCE.
  - DEBOUNCE:
    - fs[cand_row]==0: cnt++. When cnt reaches DEBOUNCE_CNT, confirm.
    - Confirm means: posicion<=cand_row*4+col_index, opr<=1, key_valid<=1 for exactly one clk, go to HELD.
    - fs[cand_row]==1: cnt=0, advance col, go to SCAN; no outputs change.
  - HELD:
    - col stays frozen.
    - fs[cand_row]==1: cnt=1, go to RELEASE.
    - Other rows and columns are ignored.
  - RELEASE:
    - fs[cand_row]==1: cnt++. At DEBOUNCE_CNT: opr<=0, cnt=0, advance col, go to SCAN.
    - fs[cand_row]==0 (bounce): cnt=0, back to HELD, no key_valid.
- posicion holds the last confirmed value after release and only changes on confirmation.
- Latency: first detecting tick + (DEBOUNCE_CNT-1) further ticks + 1 clk register delay to opr/key_valid.
- Simultaneous keys:
  - Same column: lowest row wins.
  - A key in another column pressed while one is held is not seen until release completes.
  - A held key stays reported even if a second key joins.
- key_valid never asserts twice for one physical press, including with release bounce shorter than DEBOUNCE_CNT ticks.

Decomposition:
- Shared package/include keypad_pkg:
  - FSM state encodings SCAN/DEBOUNCE/HELD/RELEASE (2-bit).
  - COL_IDLE=4'b1111, COL_FIRST=4'b1110.
  - Function/macro mapping a one-hot-low col to col_index.
- One sub-module: scan_tick_gen (param SCAN_DIV; ports clk, rst, tick).
- The synchroniser stays inline.

Test Plan:
(All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.)
1. Reset: hold rst=0 with fila=0000, then release -> col=1110, posicion=0, opr=0, key_valid=0 throughout reset; col rotates 1110->1101 after 4 clk plus sync latency.
2. Clean press row2/col1 (fila[2]=0 whenever col==1101) -> opr=1, posicion=9, key_valid high exactly 1 clk, 3 ticks after first detection; col frozen at 1101.
3. Bounce: row0/col3 asserted for 1 tick, released, then held -> no key_valid after the 1-tick glitch; confirmation arrives after 3 stable ticks, posicion=3.
4. Release bounce: while key 9 is held, release for 2 ticks, re-press, hold 5 ticks, then release cleanly -> opr stays 1 during the 2-tick gap, no second key_valid; opr=0 after 3 high ticks; posicion stays 9.
5. Multi-key: rows 1 and 3 low in col2 together -> posicion=6. While held, press row0/col0 -> ignored. After key 6 releases, row0/col0 is detected and gives posicion=0.
6. Async reset mid-DEBOUNCE and mid-HELD -> outputs return to reset values within the same cycle rst falls, with no key_valid pulse.
